// File: rtl/button_pkg.sv
// ============================================================================
// button_pkg: shared push-button types and time-to-cycle conversion.
// Revision: 1.0
// ============================================================================
`default_nettype none

package button_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESSED  = 3'd1,
        HELD     = 3'd2,
        WAIT2    = 3'd3,
        PRESSED2 = 3'd4
    } btn_state_t;

    // Widened to 64 bits so large ms values do not overflow before the divide.
    function automatic int ms_to_cycles(input int ms, input int clk_period_ns);
        longint unsigned prod;
        prod = longint'(ms) * 64'd1_000_000;
        return int'(prod / longint'(clk_period_ns));
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/edge_detect.sv
// ============================================================================
// edge_detect: registers the previous button level and flags rise / fall.
// Revision: 1.0
// ============================================================================
`default_nettype none

module edge_detect (
    input  logic clk_i,
    input  logic btn_i,
    output logic rise_o,
    output logic fall_o
);

    logic prev_q;

    // Loaded unconditionally, so reset also captures the current level.
    always_ff @(posedge clk_i) begin
        prev_q <= btn_i;
    end

    assign rise_o = btn_i & ~prev_q;
    assign fall_o = ~btn_i & prev_q;

endmodule

`default_nettype wire

// File: rtl/button_event_decoder.sv
// ============================================================================
// button_event_decoder: turns a debounced button level into one-cycle
// press / release / long / repeat / single / double pulses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_event_decoder
    import button_pkg::*;
#(
    parameter int CLK_PERIOD_NS   = 10,
    parameter int LONG_PRESS_MS   = 500,
    parameter int REPEAT_MS       = 100,
    parameter int DOUBLE_CLICK_MS = 250
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic btn_in,
    output logic press_out,
    output logic release_out,
    output logic long_out,
    output logic repeat_out,
    output logic single_out,
    output logic double_out,
    output logic held_out
);

    localparam int LONG_C = ms_to_cycles(LONG_PRESS_MS, CLK_PERIOD_NS);
    localparam int REP_C  = ms_to_cycles(REPEAT_MS, CLK_PERIOD_NS);
    localparam int DBL_C  = ms_to_cycles(DOUBLE_CLICK_MS, CLK_PERIOD_NS);
    localparam int MAX_C  = max3(LONG_C, REP_C, DBL_C);
    localparam int CNT_W  = (MAX_C > 2) ? $clog2(MAX_C) : 1;

    localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_C - 1);
    localparam logic [CNT_W-1:0] REP_T  = CNT_W'(REP_C - 1);
    localparam logic [CNT_W-1:0] DBL_T  = CNT_W'(DBL_C - 1);

    generate
        if (LONG_C < 2 || REP_C < 2 || DBL_C < 2) begin : g_bad_timing
            $error("button_event_decoder: LONG, REP and DBL must each be >= 2 cycles");
        end
    endgenerate

    logic w_rise;
    logic w_fall;

    edge_detect u_edge (
        .clk_i  (clk_in),
        .btn_i  (btn_in),
        .rise_o (w_rise),
        .fall_o (w_fall)
    );

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_clr;
    logic press_d, release_d, long_d, repeat_d, single_d, double_d, held_d;
    logic press_q, release_q, long_q, repeat_q, single_q, double_q, held_q;

    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        single_d  = 1'b0;
        double_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (w_rise) begin
                    press_d = 1'b1;
                    state_d = PRESSED;
                end
            end
            PRESSED, PRESSED2: begin
                // Fall is checked first so it beats a coincident long terminal.
                if (w_fall) begin
                    release_d = 1'b1;
                    state_d   = (state_q == PRESSED) ? WAIT2 : IDLE;
                end else if (cnt_q == LONG_T) begin
                    long_d  = 1'b1;
                    state_d = HELD;
                end
            end
            HELD: begin
                if (w_fall) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q == REP_T) begin
                    repeat_d = 1'b1;
                    cnt_clr  = 1'b1;
                end
            end
            WAIT2: begin
                if (w_rise) begin
                    press_d  = 1'b1;
                    double_d = 1'b1;
                    state_d  = PRESSED2;
                end else if (cnt_q == DBL_T) begin
                    single_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        held_d = (state_d == PRESSED) || (state_d == PRESSED2) || (state_d == HELD);
    end

    // Counter rests at zero in IDLE; leaving IDLE clears it anyway.
    always_comb begin
        if (cnt_clr || (state_d != state_q) || (state_q == IDLE)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            single_q  <= 1'b0;
            double_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            single_q  <= single_d;
            double_q  <= double_d;
            held_q    <= held_d;
        end
    end

    assign press_out   = press_q;
    assign release_out = release_q;
    assign long_out    = long_q;
    assign repeat_out  = repeat_q;
    assign single_out  = single_q;
    assign double_out  = double_q;
    assign held_out    = held_q;

endmodule

`default_nettype wire
